// File: rtl/impulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : impulse_scheduler
// Brief    : Probing-impulse train sequencer: GATE/BLANK windows and per-impulse
//            frequency strobes. IMPULSE_ABORT_EN adds an ABORT input.
// Revision : 1.0
// ============================================================================
module impulse_scheduler #(
  parameter int CNT_W  = 32,
  parameter int FREQ_W = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [63:0]       TIME,
  input  logic              SPI_WR,
`ifdef IMPULSE_ABORT_EN
  input  logic              ABORT,
`endif
  input  logic [FREQ_W-1:0] FREQ,
  input  logic [FREQ_W-1:0] FREQ_STEP,
  input  logic [63:0]       TIME_START,
  input  logic [15:0]       N_impulse,
  input  logic [7:0]        TYPE_impulse,
  input  logic [31:0]       Interval_Ti,
  input  logic [31:0]       Interval_Tp,
  input  logic [31:0]       Tblank1,
  input  logic [31:0]       Tblank2,
  output logic              GATE,
  output logic              BLANK,
  output logic [FREQ_W-1:0] FREQ_OUT,
  output logic              FREQ_UPD,
  output logic [15:0]       IMP_CNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              CFG_ERR,
  output logic              LATE
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_run  = 2'd2;
  localparam logic [1:0] c_fin  = 2'd3;
  localparam int         c_sum_w = CNT_W + 2;

  logic [1:0]         r_state, w_state_nx;
  logic [CNT_W-1:0]   r_ph, w_ph_nx;
  logic [15:0]        r_k, w_k_nx;
  logic               w_imp_start;

  logic [FREQ_W-1:0]  r_freq, r_step;
  logic [63:0]        r_tstart;
  logic [15:0]        r_n;
  logic               r_stepen;
  logic [CNT_W-1:0]   r_ti, r_tp, r_tb1, r_tb2;

  logic               r_pend;
  logic [FREQ_W-1:0]  r_p_freq, r_p_step;
  logic [63:0]        r_p_tstart;
  logic [15:0]        r_p_n;
  logic               r_p_stepen;
  logic [CNT_W-1:0]   r_p_ti, r_p_tp, r_p_tb1, r_p_tb2;

  logic [FREQ_W-1:0]  w_s_freq, w_s_step;
  logic [63:0]        w_s_tstart;
  logic [15:0]        w_s_n;
  logic               w_s_stepen;
  logic [CNT_W-1:0]   w_s_ti, w_s_tp, w_s_tb1, w_s_tb2;
  logic [c_sum_w-1:0] w_sum, w_e1, w_e2, w_e3, w_ph_x;
  logic               w_apply, w_cfg_ok, w_abort, w_unused;

  logic               w_gate_d, w_blank_d, w_upd_d, w_busy_d, w_done_d;
  logic [FREQ_W-1:0]  w_freq_d;
  logic [15:0]        w_cnt_d;

`ifdef IMPULSE_ABORT_EN
  assign w_abort = ABORT;
`else
  assign w_abort = 1'b0;
`endif
  assign w_unused = ^TYPE_impulse[7:1];

  // A direct write always wins over the buffered one.
  assign w_s_freq   = SPI_WR ? FREQ                : r_p_freq;
  assign w_s_step   = SPI_WR ? FREQ_STEP           : r_p_step;
  assign w_s_tstart = SPI_WR ? TIME_START          : r_p_tstart;
  assign w_s_n      = SPI_WR ? N_impulse           : r_p_n;
  assign w_s_stepen = SPI_WR ? TYPE_impulse[0]     : r_p_stepen;
  assign w_s_ti     = SPI_WR ? CNT_W'(Interval_Ti) : r_p_ti;
  assign w_s_tp     = SPI_WR ? CNT_W'(Interval_Tp) : r_p_tp;
  assign w_s_tb1    = SPI_WR ? CNT_W'(Tblank1)     : r_p_tb1;
  assign w_s_tb2    = SPI_WR ? CNT_W'(Tblank2)     : r_p_tb2;

  assign w_apply  = (((r_state == c_idle) || (r_state == c_fin)) && SPI_WR) ||
                    ((r_state == c_fin) && r_pend);
  assign w_sum    = c_sum_w'(w_s_tb1) + c_sum_w'(w_s_ti) + c_sum_w'(w_s_tb2);
  assign w_cfg_ok = (w_s_tp != '0) && (w_sum <= c_sum_w'(w_s_tp));

  assign w_e1   = c_sum_w'(r_tb1);
  assign w_e2   = w_e1 + c_sum_w'(r_ti);
  assign w_e3   = w_e2 + c_sum_w'(r_tb2);
  assign w_ph_x = c_sum_w'(w_ph_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_ph    <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
      r_k     <= w_k_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_ph_nx     = r_ph;
    w_k_nx      = r_k;
    w_imp_start = 1'b0;
    case (r_state)
      c_idle, c_fin: begin
        w_state_nx = c_idle;
        if (w_apply && w_cfg_ok)
          w_state_nx = (w_s_n == 16'd0) ? c_fin : c_wait;
      end
      c_wait: begin
        if (w_abort) begin
          w_state_nx = c_fin;
        end else if (clk_en && (TIME >= r_tstart)) begin
          w_state_nx  = c_run;
          w_ph_nx     = '0;
          w_k_nx      = '0;
          w_imp_start = 1'b1;
        end
      end
      c_run: begin
        if (w_abort) begin
          w_state_nx = c_fin;
        end else if (clk_en) begin
          if (r_ph == r_tp - CNT_W'(1)) begin
            if (r_k == r_n - 16'd1) begin
              w_state_nx = c_fin;
            end else begin
              w_k_nx      = r_k + 16'd1;
              w_ph_nx     = '0;
              w_imp_start = 1'b1;
            end
          end else begin
            w_ph_nx = r_ph + CNT_W'(1);
          end
        end
      end
      default: w_state_nx = c_idle;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    w_gate_d  = 1'b0;
    w_blank_d = 1'b0;
    w_busy_d  = (w_state_nx == c_wait) || (w_state_nx == c_run);
    w_done_d  = (w_state_nx == c_fin);
    w_upd_d   = w_imp_start;
    w_freq_d  = FREQ_OUT;
    w_cnt_d   = IMP_CNT;
    if (w_state_nx == c_run) begin
      w_gate_d  = (w_ph_x >= w_e1) && (w_ph_x < w_e2);
      w_blank_d = (w_ph_x < w_e1) || ((w_ph_x >= w_e2) && (w_ph_x < w_e3));
    end
    if (w_imp_start) begin
      w_cnt_d = w_k_nx;
      if (r_state == c_wait)
        w_freq_d = r_freq;
      else if (r_stepen)
        w_freq_d = FREQ_OUT + r_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GATE     <= 1'b0;
      BLANK    <= 1'b0;
      FREQ_UPD <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      FREQ_OUT <= '0;
      IMP_CNT  <= '0;
    end else begin
      GATE     <= w_gate_d;
      BLANK    <= w_blank_d;
      FREQ_UPD <= w_upd_d;
      BUSY     <= w_busy_d;
      DONE     <= w_done_d;
      FREQ_OUT <= w_freq_d;
      IMP_CNT  <= w_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq   <= '0;
      r_step   <= '0;
      r_tstart <= '0;
      r_n      <= '0;
      r_stepen <= 1'b0;
      r_ti     <= '0;
      r_tp     <= '0;
      r_tb1    <= '0;
      r_tb2    <= '0;
      CFG_ERR  <= 1'b0;
      LATE     <= 1'b0;
    end else begin
      if (w_apply) begin
        r_freq   <= w_s_freq;
        r_step   <= w_s_step;
        r_tstart <= w_s_tstart;
        r_n      <= w_s_n;
        r_stepen <= w_s_stepen;
        r_ti     <= w_s_ti;
        r_tp     <= w_s_tp;
        r_tb1    <= w_s_tb1;
        r_tb2    <= w_s_tb2;
        CFG_ERR  <= !w_cfg_ok;
        LATE     <= 1'b0;
      end else if ((r_state == c_wait) && w_imp_start && (TIME > r_tstart)) begin
        LATE <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_p_freq   <= '0;
      r_p_step   <= '0;
      r_p_tstart <= '0;
      r_p_n      <= '0;
      r_p_stepen <= 1'b0;
      r_p_ti     <= '0;
      r_p_tp     <= '0;
      r_p_tb1    <= '0;
      r_p_tb2    <= '0;
    end else if (((r_state == c_wait) || (r_state == c_run)) && SPI_WR) begin
      r_pend     <= 1'b1;
      r_p_freq   <= FREQ;
      r_p_step   <= FREQ_STEP;
      r_p_tstart <= TIME_START;
      r_p_n      <= N_impulse;
      r_p_stepen <= TYPE_impulse[0];
      r_p_ti     <= CNT_W'(Interval_Ti);
      r_p_tp     <= CNT_W'(Interval_Tp);
      r_p_tb1    <= CNT_W'(Tblank1);
      r_p_tb2    <= CNT_W'(Tblank2);
    end else if (r_state == c_fin) begin
      r_pend <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_impulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_impulse_scheduler
// Brief    : Self-checking bench for impulse_scheduler against a tick-count model.
// Revision : 1.0
// ============================================================================
module tb_impulse_scheduler;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] step;
    logic [63:0] ts;
    logic [15:0] n;
    logic [7:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [63:0] TIME = 64'd0;
  logic        SPI_WR = 1'b0;
  logic [47:0] FREQ = '0, FREQ_STEP = '0;
  logic [63:0] TIME_START = '0;
  logic [15:0] N_impulse = '0;
  logic [7:0]  TYPE_impulse = '0;
  logic [31:0] Interval_Ti = '0, Interval_Tp = '0, Tblank1 = '0, Tblank2 = '0;
  logic        GATE, BLANK, FREQ_UPD, BUSY, DONE, CFG_ERR, LATE;
  logic [47:0] FREQ_OUT;
  logic [15:0] IMP_CNT;
`ifdef IMPULSE_ABORT_EN
  logic        ABORT = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int en_mode = 0;

  // Reference model: train position is the tick count since start.
  int              m_mode;
  cfg_t            m_cfg, m_pcfg;
  bit              m_pv;
  longint unsigned m_t;
  bit              e_gate, e_blank, e_upd, e_busy, e_done, e_err, e_late;
  logic [47:0]     e_freq;
  logic [15:0]     e_cnt;

  always #5 clk = ~clk;

  impulse_scheduler #(.CNT_W(32), .FREQ_W(48)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .TIME         (TIME),
    .SPI_WR       (SPI_WR),
`ifdef IMPULSE_ABORT_EN
    .ABORT        (ABORT),
`endif
    .FREQ         (FREQ),
    .FREQ_STEP    (FREQ_STEP),
    .TIME_START   (TIME_START),
    .N_impulse    (N_impulse),
    .TYPE_impulse (TYPE_impulse),
    .Interval_Ti  (Interval_Ti),
    .Interval_Tp  (Interval_Tp),
    .Tblank1      (Tblank1),
    .Tblank2      (Tblank2),
    .GATE         (GATE),
    .BLANK        (BLANK),
    .FREQ_OUT     (FREQ_OUT),
    .FREQ_UPD     (FREQ_UPD),
    .IMP_CNT      (IMP_CNT),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .CFG_ERR      (CFG_ERR),
    .LATE         (LATE)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cfg_t mk(input int tb1, input int ti, input int tb2, input int tp,
                              input int n, input logic [47:0] f, input logic [47:0] s,
                              input logic [7:0] typ, input logic [63:0] ts);
    cfg_t c;
    c.tb1 = tb1; c.ti = ti; c.tb2 = tb2; c.tp = tp; c.n = 16'(n);
    c.freq = f; c.step = s; c.typ = typ; c.ts = ts;
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    int   sum;
    c.tb1  = $urandom % 4;
    c.ti   = $urandom % 5;
    c.tb2  = $urandom % 3;
    sum    = int'(c.tb1 + c.ti + c.tb2);
    c.tp   = (($urandom % 8) == 0) ? 32'(sum - 1) : 32'(sum + int'($urandom % 4));
    if (sum == 0 && c.tp == 32'hFFFF_FFFF) c.tp = 0;
    c.n    = 16'($urandom % 4);
    c.freq = {$urandom, $urandom} ;
    c.step = {$urandom, $urandom};
    c.typ  = 8'($urandom);
    c.ts   = TIME + 64'($urandom % 14) - 64'd4;
    return c;
  endfunction

  function automatic bit cfg_valid(input cfg_t c);
    longint unsigned s;
    s = 64'(c.tb1) + 64'(c.ti) + 64'(c.tb2);
    return (c.tp != 0) && (s <= 64'(c.tp));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pv = 0; m_t = 0;
    e_gate = 0; e_blank = 0; e_upd = 0; e_busy = 0; e_done = 0;
    e_err = 0; e_late = 0; e_freq = '0; e_cnt = '0;
  endtask

  task automatic model_edge(input bit en, input logic [63:0] t, input bit wr, input cfg_t c);
    bit              ap;
    cfg_t            src;
    longint unsigned ph, k, lo, hi;
    e_upd = 0;
    ap = 0;
    src = c;
    case (m_mode)
      0, 3: begin
        if (wr) ap = 1;
        else if (m_mode == 3 && m_pv) begin ap = 1; src = m_pcfg; end
        if (m_mode == 3) m_pv = 0;
        m_mode = 0;
        if (ap) begin
          m_cfg  = src;
          e_late = 0;
          e_err  = !cfg_valid(src);
          if (!e_err) m_mode = (src.n == 0) ? 3 : 1;
        end
      end
      1: begin
        if (wr) begin m_pv = 1; m_pcfg = c; end
        if (en && t >= m_cfg.ts) begin
          m_mode = 2; m_t = 0; e_upd = 1;
          if (t > m_cfg.ts) e_late = 1;
        end
      end
      default: begin
        if (wr) begin m_pv = 1; m_pcfg = c; end
        if (en) begin
          m_t++;
          if (m_t == 64'(m_cfg.n) * 64'(m_cfg.tp)) m_mode = 3;
          else if (m_t % 64'(m_cfg.tp) == 0) e_upd = 1;
        end
      end
    endcase
    e_busy = (m_mode == 1) || (m_mode == 2);
    e_done = (m_mode == 3);
    e_gate = 0; e_blank = 0;
    if (m_mode == 2) begin
      ph = m_t % 64'(m_cfg.tp);
      k  = m_t / 64'(m_cfg.tp);
      lo = 64'(m_cfg.tb1);
      hi = lo + 64'(m_cfg.ti);
      e_gate  = (ph >= lo) && (ph < hi);
      e_blank = (ph < lo) || ((ph >= hi) && (ph < hi + 64'(m_cfg.tb2)));
      if (e_upd) begin
        e_cnt  = 16'(k);
        e_freq = m_cfg.typ[0] ? (m_cfg.freq + 48'(k) * m_cfg.step) : m_cfg.freq;
      end
    end
  endtask

  task automatic compare_all();
    check("gate",     GATE,     e_gate);
    check("blank",    BLANK,    e_blank);
    check("freq_upd", FREQ_UPD, e_upd);
    check("busy",     BUSY,     e_busy);
    check("done",     DONE,     e_done);
    check("freq_out", FREQ_OUT, e_freq);
    check("imp_cnt",  IMP_CNT,  e_cnt);
    check("cfg_err",  CFG_ERR,  e_err);
    check("late",     LATE,     e_late);
    check("excl",     GATE & BLANK, 1'b0);
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model, check after the edge.
  task automatic step(input bit wr, input cfg_t c);
    cyc++;
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = (cyc % 4 == 0);
      default: clk_en = 1'($urandom % 2);
    endcase
    TIME         = TIME + 64'd1;
    SPI_WR       = wr;
    FREQ         = c.freq;
    FREQ_STEP    = c.step;
    TIME_START   = c.ts;
    N_impulse    = c.n;
    TYPE_impulse = c.typ;
    Interval_Ti  = c.ti;
    Interval_Tp  = c.tp;
    Tblank1      = c.tb1;
    Tblank2      = c.tb2;
    model_edge(clk_en, TIME, wr, c);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget && m_mode != 0; i++) step(1'b0, rand_cfg());
    check("train_timeout", 64'(m_mode), 64'd0);
  endtask

  initial begin
    cfg_t a, b;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Basic train: 2-3-1 window in a 10-tick period, twice.
    en_mode = 0;
    step(1'b1, mk(2, 3, 1, 10, 2, 48'd100, 48'd7, 8'd0, TIME + 64'd6));
    run_idle(100);

    // Frequency stepping and modulo wrap.
    step(1'b1, mk(1, 1, 0, 3, 3, 48'd1, 48'd2, 8'd1, TIME + 64'd3));
    run_idle(100);
    step(1'b1, mk(0, 1, 1, 2, 2, 48'hFFFF_FFFF_FFFF, 48'd1, 8'd1, TIME + 64'd2));
    run_idle(100);

    // Rejected set, then N=0 set.
    step(1'b1, mk(5, 5, 1, 10, 2, 48'd9, 48'd1, 8'd0, TIME + 64'd2));
    repeat (3) step(1'b0, rand_cfg());
    step(1'b1, mk(1, 1, 1, 4, 0, 48'd9, 48'd1, 8'd0, TIME + 64'd2));
    run_idle(20);

    // Start time already in the past.
    step(1'b1, mk(1, 2, 1, 5, 1, 48'd5, 48'd1, 8'd0, TIME - 64'd3));
    run_idle(50);

    // Pending write mid-train with a longer period.
    a = mk(2, 3, 1, 10, 2, 48'd50, 48'd1, 8'd1, TIME + 64'd3);
    b = mk(3, 4, 2, 20, 1, 48'd70, 48'd1, 8'd0, 64'd0);
    step(1'b1, a);
    for (int i = 0; i < 100 && !(m_mode == 2 && m_t == 5); i++) step(1'b0, rand_cfg());
    step(1'b1, b);
    run_idle(200);

    // Slow ticks, then reset in the middle of a gate.
    en_mode = 1;
    step(1'b1, mk(1, 2, 1, 6, 2, 48'd3, 48'd1, 8'd0, TIME + 64'd2));
    for (int i = 0; i < 300 && !e_gate; i++) step(1'b0, rand_cfg());
    #2 rst_n = 1'b0;
    #1;
    check("rst_gate",  GATE,  1'b0);
    check("rst_blank", BLANK, 1'b0);
    check("rst_busy",  BUSY,  1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare_all();

    // Random traffic, including writes in every state.
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) en_mode = int'($urandom % 3);
      step(1'($urandom % 25 == 0), rand_cfg());
    end
    en_mode = 0;
    run_idle(400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
